issue_scoreboard: RTL and testbench
===================================

# issue_scoreboard

In-order issue controller between the decode queue and the four execute units (alu, mul, jmp, mem). Each cycle it examines the queue head (`ctrl_sigs::queue_item_t`) and checks RAW/WAW hazards against a 32-entry register scoreboard. When the target unit's `exu_type` is ready, it dispatches the head to that unit and pops the queue. Writeback ports clear scoreboard bits. A flush parks the block in a drain state until all in-flight results have returned.

## Interface
- `NUM_WB`, default 2: number of writeback ports that clear scoreboard bits.
- `clk  in  1`: clock; all state updates on the rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `q_valid  in  1`: queue head is valid.
- `q_item  in  50`: queue head, `queue_item_t` (packed).
- `q_deq  out  1`: pop the queue head this cycle; equals `fire`.
- `exu_ready  in  4`: per-unit ready, indexed by `exut::exe_unit_type_t`.
- `iss_valid  out  4`: one-hot issue strobe, indexed by `exu_type`.
- `iss_item  out  50`: `q_item` passed through.
- `wb_valid  in  NUM_WB`: writeback strobes.
- `wb_rd  in  5*NUM_WB`: writeback destination registers; port k uses bits [5k+4:5k].
- `flush  in  1`: pipeline flush (mispredict/redirect).
- `busy  out  32`: registered scoreboard; bit 0 is always 0.
- `idle  out  1`: high when state is RUN and `busy == 0`.
- `stall_cnt  out  32`: saturating count of hazard/structural stall cycles.

## Operation
- **Scoreboard update**
  - `clr_mask`: OR over k of `wb_valid[k] ? (1<<wb_rd[k]) : 0`, with bit 0 forced to 0.
  - `eff_busy = busy & ~clr_mask`. This is a same-cycle writeback bypass: a result returning this cycle unblocks a dependent in the same cycle.
- **Hazard check** on the head:
  - `raw1 = has_rs1 & rs1!=0 & eff_busy[rs1]`.
  - `raw2 = has_rs2 & rs2!=0 & eff_busy[rs2]`.
  - `waw = has_rd & rd!=0 & eff_busy[rd]`.
- **Issue**
  - `fire = (state==RUN) & q_valid & ~flush & exu_ready[exu_type] & ~raw1 & ~raw2 & ~waw`.
  - `iss_valid = fire ? (4'b1 << exu_type) : 0`.
  - At most one issue per cycle; strictly in order, with no bypassing of a stalled head.
- **Next busy**
  - `busy_n = eff_busy | set_mask`, where `set_mask = (fire & has_rd & rd!=0) ? (1<<rd) : 0`.
  - The set wins over a clear to the same register in the same cycle.
  - Multiple writeback ports naming the same rd are legal; the bit clears once.
- **FSM states**: RUN, DRAIN.
  - RUN with `flush`: no issue this cycle. Go to DRAIN if `busy_n != 0`, else stay in RUN.
  - DRAIN: no issue and `q_deq = 0`. Return to RUN in the cycle after `busy_n == 0`. `flush` while in DRAIN has no additional effect.
  - Queue contents are discarded by the queue owner on `flush`; this block never pops on a flush cycle.
- **Stall counter**
  - Increments when `state==RUN & q_valid & ~flush & ~fire`.
  - Saturates at 32'hFFFF_FFFF and never wraps.
  - Does not count in DRAIN.

## Timing
- **Reset**: `busy = 0`, state = RUN, `stall_cnt = 0`.
  - Outputs during reset: `idle = 1`, `q_deq = 0`, `iss_valid = 0`.
  - Reset asserted mid-drain returns to RUN with the scoreboard cleared.
- **Combinational paths**: `q_deq`, `iss_valid` and `iss_item` are combinational from `q_valid`, `q_item`, `exu_ready`, `wb_*`, `flush` and the registered state. Issue latency is 0 cycles from head-valid.
- **Scoreboard visibility**: scoreboard set and clear take effect on the next rising edge. The clear is also visible combinationally to the same-cycle hazard check.
- **Drain**: minimum DRAIN residency is 1 cycle. If all busy bits clear in the flush cycle, the block stays in RUN and the first post-flush issue can occur on the next cycle.
- **Handshake**: the execute unit accepts the issue iff `iss_valid[k] & exu_ready[k]`. `exu_ready` may drop at any time; the head is then held, with no issue.

## Test plan
- **Back-to-back independent ops**
  - Stimulus: `addi x1`, `addi x2`, all units ready.
  - Response: `fire` on 2 consecutive cycles; `busy = 0x6` after the second edge.
- **RAW stall**
  - Stimulus: `mul x5` issues, then `add x6, x5, x1` is at the head; `wb_valid[0]` with `wb_rd = 5` arrives 3 cycles later.
  - Response: add stalls 3 cycles (`stall_cnt = 3`) and issues in the writeback cycle via the bypass; `busy[5] = 0`, `busy[6] = 1`.
- **WAW and set-over-clear**
  - Stimulus: `busy[7] = 1`; in the same cycle, writeback to x7 and a head with `rd = 7`.
  - Response: issues; `busy[7]` remains 1.
- **x0 handling**
  - Stimulus: an op with `rd = 0` issues, then an op with `rs1 = 0`.
  - Response: `busy` is unchanged and the op with `rs1 = 0` never stalls.
- **Flush drain**
  - Stimulus: `busy = 0x30`; `flush`; writebacks to x4 and x5 on successive cycles.
  - Response: `q_deq = 0` throughout DRAIN; return to RUN the cycle after the x5 writeback; `idle = 1`.
- **Structural stall and reset**
  - Stimulus: `exu_ready[mem] = 0` with a load at the head for 4 cycles; then `rst` is pulsed mid-DRAIN.
  - Response: no issue and `stall_cnt = 4`; after reset `busy = 0`, state = RUN and `stall_cnt = 0`.

Source files
------------

// File: rtl/issue_scoreboard.sv
// In-order issue controller: RAW/WAW hazard check against a 32-entry register scoreboard,
// one dispatch per cycle to alu/mul/jmp/mem, and a flush drain that waits for in-flight results.

package exut;
  typedef enum logic [1:0] {
    EXU_ALU = 2'd0,
    EXU_MUL = 2'd1,
    EXU_JMP = 2'd2,
    EXU_MEM = 2'd3
  } exe_unit_type_t;
endpackage

package ctrl_sigs;
  localparam int unsigned REG_W = 5;
  localparam int unsigned OP_W  = 7;
  localparam int unsigned IMM_W = 23;

  // 50-bit decode queue entry
  typedef struct packed {
    exut::exe_unit_type_t exu_type;
    logic [OP_W-1:0]      op;
    logic                 has_rd;
    logic [REG_W-1:0]     rd;
    logic                 has_rs1;
    logic [REG_W-1:0]     rs1;
    logic                 has_rs2;
    logic [REG_W-1:0]     rs2;
    logic [IMM_W-1:0]     imm;
  } queue_item_t;
endpackage

module issue_scoreboard
  import ctrl_sigs::*;
#(
  parameter int unsigned NUM_WB = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  q_valid,
  input  queue_item_t           q_item,
  output logic                  q_deq,
  input  logic [3:0]            exu_ready,
  output logic [3:0]            iss_valid,
  output queue_item_t           iss_item,
  input  logic [NUM_WB-1:0]     wb_valid,
  input  logic [5*NUM_WB-1:0]   wb_rd,
  input  logic                  flush,
  output logic [31:0]           busy,
  output logic                  idle,
  output logic [31:0]           stall_cnt
);

  localparam int unsigned NREG  = 32;
  localparam int unsigned CNT_W = 32;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [NREG-1:0]   clr_mask;
  logic [NREG-1:0]   set_mask;
  logic [NREG-1:0]   eff_busy;
  logic [NREG-1:0]   busy_n;
  logic              raw1, raw2, waw;
  logic              unit_ready;
  logic              fire;
  logic              stall_inc;

  // Writeback clears; x0 is never tracked
  always_comb begin
    clr_mask = '0;
    for (int unsigned k = 0; k < NUM_WB; k++) begin
      if (wb_valid[k]) clr_mask[wb_rd[REG_W*k +: REG_W]] = 1'b1;
    end
    clr_mask[0] = 1'b0;
  end

  // Same-cycle writeback bypass into the hazard check
  assign eff_busy   = busy & ~clr_mask;
  assign raw1       = q_item.has_rs1 && (q_item.rs1 != '0) && eff_busy[q_item.rs1];
  assign raw2       = q_item.has_rs2 && (q_item.rs2 != '0) && eff_busy[q_item.rs2];
  assign waw        = q_item.has_rd  && (q_item.rd  != '0) && eff_busy[q_item.rd];
  assign unit_ready = exu_ready[2'(q_item.exu_type)];

  // Next-state, issue and scoreboard set
  always_comb begin
    state_d  = state_q;
    fire     = 1'b0;
    set_mask = '0;
    case (state_q)
      ST_RUN: begin
        fire = !rst && q_valid && !flush && unit_ready && !raw1 && !raw2 && !waw;
        if (fire && q_item.has_rd && (q_item.rd != '0)) set_mask[q_item.rd] = 1'b1;
        if (flush && (eff_busy != '0)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (eff_busy == '0) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign busy_n    = eff_busy | set_mask;
  assign stall_inc = (state_q == ST_RUN) && q_valid && !flush && !fire;

  assign q_deq     = fire;
  assign iss_valid = fire ? (4'(1) << q_item.exu_type) : 4'b0000;
  assign iss_item  = q_item;
  assign idle      = (state_q == ST_RUN) && (busy == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      busy      <= '0;
      stall_cnt <= '0;
    end else begin
      state_q <= state_d;
      busy    <= busy_n;
      if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed vector table for the scenario sequences, then
// random traffic checked against an array-based scoreboard model.

module tb_issue_scoreboard;
  import ctrl_sigs::*;

  logic               clk;
  logic               rst;
  logic               q_valid;
  queue_item_t        q_item;
  logic               q_deq;
  logic [3:0]         exu_ready;
  logic [3:0]         iss_valid;
  queue_item_t        iss_item;
  logic [1:0]         wb_valid;
  logic [9:0]         wb_rd;
  logic               flush;
  logic [31:0]        busy;
  logic               idle;
  logic [31:0]        stall_cnt;

  int total = 0;
  int bad   = 0;

  issue_scoreboard #(.NUM_WB(2)) dut (
    .clk(clk), .rst(rst), .q_valid(q_valid), .q_item(q_item), .q_deq(q_deq),
    .exu_ready(exu_ready), .iss_valid(iss_valid), .iss_item(iss_item),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .busy(busy), .idle(idle),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           qv;
    queue_item_t  item;
    logic [3:0]   rdy;
    logic [1:0]   wbv;
    logic [9:0]   wbrd;
    bit           fl;
    bit           e_deq;
    logic [3:0]   e_iss;
    logic [31:0]  e_busy;
    int           e_stall;
    bit           e_idle;
  } vec_t;

  vec_t tbl[$];

  // Reference model: one flag per architectural register, a drain flag and a stall counter
  bit              sb[32];
  bit              clr_m[32];
  bit              m_drain;
  longint unsigned m_stall;

  function automatic queue_item_t mk(input int t, input int hrd, input int rd,
                                     input int h1, input int r1, input int h2, input int r2);
    queue_item_t it;
    it.exu_type = exut::exe_unit_type_t'(2'(t));
    it.op       = 7'(rd * 3 + t);
    it.has_rd   = (hrd != 0);
    it.rd       = 5'(rd);
    it.has_rs1  = (h1 != 0);
    it.rs1      = 5'(r1);
    it.has_rs2  = (h2 != 0);
    it.rs2      = 5'(r2);
    it.imm      = 23'(r1 * 97 + r2 * 13 + rd);
    return it;
  endfunction

  function automatic vec_t V(input bit qv, input queue_item_t item, input logic [3:0] rdy,
                             input logic [1:0] wbv, input int wb1, input int wb0, input bit fl,
                             input bit e_deq, input logic [3:0] e_iss, input logic [31:0] e_busy,
                             input int e_stall, input bit e_idle);
    vec_t v;
    v.qv = qv; v.item = item; v.rdy = rdy; v.wbv = wbv;
    v.wbrd = {5'(wb1), 5'(wb0)}; v.fl = fl;
    v.e_deq = e_deq; v.e_iss = e_iss; v.e_busy = e_busy; v.e_stall = e_stall; v.e_idle = e_idle;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) sb[r] = 1'b0;
    m_drain = 1'b0;
    m_stall = 0;
  endtask

  function automatic bit blocked(input bit h, input logic [4:0] r);
    return h && (r != 0) && sb[r] && !clr_m[r];
  endfunction

  // Apply one cycle of inputs, check mid-cycle, then advance model and clock
  task automatic step(input vec_t v, input bit use_exp);
    bit          go;
    bit          any;
    logic [31:0] mb;
    logic [3:0]  miss;
    int          t;
    q_valid = v.qv; q_item = v.item; exu_ready = v.rdy;
    wb_valid = v.wbv; wb_rd = v.wbrd; flush = v.fl;
    #3;
    for (int r = 0; r < 32; r++) clr_m[r] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      int wr;
      wr = int'(v.wbrd[k*5 +: 5]);
      if (v.wbv[k] && wr != 0) clr_m[wr] = 1'b1;
    end
    mb = '0;
    for (int r = 0; r < 32; r++) mb[r] = sb[r];
    t = int'(v.item.exu_type);
    go = !m_drain && v.qv && !v.fl && v.rdy[t] &&
         !blocked(v.item.has_rs1, v.item.rs1) && !blocked(v.item.has_rs2, v.item.rs2) &&
         !blocked(v.item.has_rd, v.item.rd);
    miss = 4'b0000;
    if (go) miss[t] = 1'b1;

    chk("q_deq",     64'(q_deq),     64'(go));
    chk("iss_valid", 64'(iss_valid), 64'(miss));
    chk("iss_item",  64'(iss_item),  64'(v.item));
    chk("busy",      64'(busy),      64'(mb));
    chk("idle",      64'(idle),      64'(!m_drain && mb == 0));
    chk("stall_cnt", 64'(stall_cnt), m_stall);
    if (use_exp) begin
      chk("vec_deq",   64'(q_deq),     64'(v.e_deq));
      chk("vec_iss",   64'(iss_valid), 64'(v.e_iss));
      chk("vec_busy",  64'(busy),      64'(v.e_busy));
      chk("vec_stall", 64'(stall_cnt), 64'(v.e_stall));
      chk("vec_idle",  64'(idle),      64'(v.e_idle));
    end

    for (int r = 0; r < 32; r++) if (clr_m[r]) sb[r] = 1'b0;
    if (go && v.item.has_rd && v.item.rd != 0) sb[v.item.rd] = 1'b1;
    any = 1'b0;
    for (int r = 0; r < 32; r++) any |= sb[r];
    if (!m_drain && v.qv && !v.fl && !go && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (!m_drain && v.fl && any) m_drain = 1'b1;
    else if (m_drain && !any) m_drain = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    queue_item_t a1, a2, z, m5, add6, w7, r0, l0, j0, a4, m5b, ind, ld;
    vec_t v;
    a1   = mk(0, 1, 1, 1, 0, 0, 0);
    a2   = mk(0, 1, 2, 1, 0, 0, 0);
    z    = mk(0, 0, 0, 0, 0, 0, 0);
    m5   = mk(1, 1, 5, 1, 3, 1, 4);
    add6 = mk(0, 1, 6, 1, 5, 1, 1);
    w7   = mk(0, 1, 7, 0, 0, 0, 0);
    r0   = mk(0, 1, 0, 1, 0, 0, 0);
    l0   = mk(3, 0, 0, 1, 0, 0, 0);
    j0   = mk(2, 0, 0, 1, 0, 1, 0);
    a4   = mk(0, 1, 4, 0, 0, 0, 0);
    m5b  = mk(1, 1, 5, 1, 1, 0, 0);
    ind  = mk(0, 1, 9, 1, 1, 0, 0);
    ld   = mk(3, 1, 8, 1, 9, 0, 0);

    //        qv  item  rdy     wbv   wb1 wb0 fl  deq iss     busy       stall idle
    tbl.push_back(V(0, z,    4'hF, 2'b00, 0, 0, 0, 0, 4'h0, 32'h0,     0, 1));
    tbl.push_back(V(1, a1,   4'hF, 2'b00, 0, 0, 0, 1, 4'h1, 32'h0,     0, 1));
    tbl.push_back(V(1, a2,   4'hF, 2'b00, 0, 0, 0, 1, 4'h1, 32'h2,     0, 0));
    tbl.push_back(V(0, z,    4'hF, 2'b00, 0, 0, 0, 0, 4'h0, 32'h6,     0, 0));
    tbl.push_back(V(0, z,    4'hF, 2'b11, 2, 1, 0, 0, 4'h0, 32'h6,     0, 0));
    tbl.push_back(V(0, z,    4'hF, 2'b00, 0, 0, 0, 0, 4'h0, 32'h0,     0, 1));
    tbl.push_back(V(1, m5,   4'hF, 2'b00, 0, 0, 0, 1, 4'h2, 32'h0,     0, 1));
    tbl.push_back(V(1, add6, 4'hF, 2'b00, 0, 0, 0, 0, 4'h0, 32'h20,    0, 0));
    tbl.push_back(V(1, add6, 4'hF, 2'b00, 0, 0, 0, 0, 4'h0, 32'h20,    1, 0));
    tbl.push_back(V(1, add6, 4'hF, 2'b00, 0, 0, 0, 0, 4'h0, 32'h20,    2, 0));
    tbl.push_back(V(1, add6, 4'hF, 2'b01, 0, 5, 0, 1, 4'h1, 32'h20,    3, 0));
    tbl.push_back(V(0, z,    4'hF, 2'b00, 0, 0, 0, 0, 4'h0, 32'h40,    3, 0));
    tbl.push_back(V(1, w7,   4'hF, 2'b00, 0, 0, 0, 1, 4'h1, 32'h40,    3, 0));
    tbl.push_back(V(1, w7,   4'hF, 2'b10, 7, 0, 0, 1, 4'h1, 32'hC0,    3, 0));
    tbl.push_back(V(0, z,    4'hF, 2'b00, 0, 0, 0, 0, 4'h0, 32'hC0,    3, 0));
    tbl.push_back(V(1, r0,   4'hF, 2'b00, 0, 0, 0, 1, 4'h1, 32'hC0,    3, 0));
    tbl.push_back(V(1, l0,   4'hF, 2'b00, 0, 0, 0, 1, 4'h8, 32'hC0,    3, 0));
    tbl.push_back(V(1, j0,   4'hF, 2'b00, 0, 0, 0, 1, 4'h4, 32'hC0,    3, 0));
    tbl.push_back(V(0, z,    4'hF, 2'b11, 7, 6, 0, 0, 4'h0, 32'hC0,    3, 0));
    tbl.push_back(V(0, z,    4'hF, 2'b00, 0, 0, 0, 0, 4'h0, 32'h0,     3, 1));
    tbl.push_back(V(1, a4,   4'hF, 2'b00, 0, 0, 0, 1, 4'h1, 32'h0,     3, 1));
    tbl.push_back(V(1, m5b,  4'hF, 2'b00, 0, 0, 0, 1, 4'h2, 32'h10,    3, 0));
    tbl.push_back(V(1, ind,  4'hF, 2'b00, 0, 0, 1, 0, 4'h0, 32'h30,    3, 0));
    tbl.push_back(V(1, ind,  4'hF, 2'b01, 0, 4, 0, 0, 4'h0, 32'h30,    3, 0));
    tbl.push_back(V(1, ind,  4'hF, 2'b01, 0, 5, 0, 0, 4'h0, 32'h20,    3, 0));
    tbl.push_back(V(0, z,    4'hF, 2'b00, 0, 0, 0, 0, 4'h0, 32'h0,     3, 1));
    tbl.push_back(V(1, ld,   4'h7, 2'b00, 0, 0, 0, 0, 4'h0, 32'h0,     3, 1));
    tbl.push_back(V(1, ld,   4'h7, 2'b00, 0, 0, 0, 0, 4'h0, 32'h0,     4, 1));
    tbl.push_back(V(1, ld,   4'h7, 2'b00, 0, 0, 0, 0, 4'h0, 32'h0,     5, 1));
    tbl.push_back(V(1, ld,   4'h7, 2'b00, 0, 0, 0, 0, 4'h0, 32'h0,     6, 1));
    tbl.push_back(V(1, ld,   4'hF, 2'b00, 0, 0, 0, 1, 4'h8, 32'h0,     7, 1));
    tbl.push_back(V(0, z,    4'hF, 2'b00, 0, 0, 1, 0, 4'h0, 32'h100,   7, 0));
    tbl.push_back(V(0, z,    4'hF, 2'b00, 0, 0, 0, 0, 4'h0, 32'h100,   7, 0));

    // Reset with a ready, valid head present: nothing may issue
    rst = 1'b1; q_valid = 1'b1; q_item = ind; exu_ready = 4'hF;
    wb_valid = 2'b00; wb_rd = '0; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_deq",   64'(q_deq),     64'(0));
    chk("rst_iss",   64'(iss_valid), 64'(0));
    chk("rst_busy",  64'(busy),      64'(0));
    chk("rst_stall", 64'(stall_cnt), 64'(0));
    chk("rst_idle",  64'(idle),      64'(1));
    rst = 1'b0;

    foreach (tbl[i]) step(tbl[i], 1'b1);

    // Reset pulsed mid-drain: back to RUN with an empty scoreboard
    rst = 1'b1; q_valid = 1'b1; q_item = ind; exu_ready = 4'hF; flush = 1'b0; wb_valid = 2'b00;
    #3;
    chk("mid_rst_deq",   64'(q_deq),     64'(0));
    chk("mid_rst_iss",   64'(iss_valid), 64'(0));
    chk("mid_rst_busy",  64'(busy),      64'(0));
    chk("mid_rst_stall", 64'(stall_cnt), 64'(0));
    chk("mid_rst_idle",  64'(idle),      64'(1));
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Flush with nothing in flight stays in RUN; issue resumes the next cycle
    step(V(1, ind, 4'hF, 2'b00, 0, 0, 1, 0, 4'h0, 32'h0,   0, 1), 1'b1);
    step(V(1, ind, 4'hF, 2'b00, 0, 0, 0, 1, 4'h1, 32'h0,   0, 1), 1'b1);
    step(V(0, z,   4'hF, 2'b00, 0, 0, 0, 0, 4'h0, 32'h200, 0, 0), 1'b1);
    // Two ports clearing the same register in one cycle
    step(V(0, z,   4'hF, 2'b11, 9, 9, 0, 0, 4'h0, 32'h200, 0, 0), 1'b1);
    step(V(0, z,   4'hF, 2'b00, 0, 0, 0, 0, 4'h0, 32'h0,   0, 1), 1'b1);

    // Random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      v.qv   = ($urandom_range(0, 3) != 0);
      v.item = mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
      for (int i = 0; i < 4; i++) v.rdy[i] = ($urandom_range(0, 4) != 0);
      v.wbv  = 2'($urandom_range(0, 3));
      v.wbrd = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      v.fl   = ($urandom_range(0, 31) == 0);
      step(v, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
